// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the hazard/sequencing controller (master) and the
// pipeline datapath plus mult/div unit (slave).
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             ex_is_load;
    logic [4:0]       ex_rd;
    logic             ex_is_md;
    logic             md_ready;
    logic             md_exc;
    logic             branch_taken;

    logic             pc_en;
    logic             fd_en;
    logic             dx_en;
    logic             xm_en;
    logic             mw_en;
    logic             fd_flush;
    logic             dx_flush;
    logic             xm_flush;
    logic             pc_sel_target;
    logic             md_start;
    logic             md_busy;
    logic             md_exc_out;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_is_load, ex_rd,
               ex_is_md, md_ready, md_exc, branch_taken,
        output pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush,
               xm_flush, pc_sel_target, md_start, md_busy, md_exc_out,
               stall_cycles
    );

    modport slave (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_is_load, ex_rd,
               ex_is_md, md_ready, md_exc, branch_taken,
        input  pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush,
               xm_flush, pc_sel_target, md_start, md_busy, md_exc_out,
               stall_cycles
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: latch enables,
// bubbles, branch redirect, mult/div start/wait/done sequencing, stall counter.
module pipeline_ctrl #(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 32
) (
    input  logic           clock,
    input  logic           reset,
    pipeline_ctrl_if.master bus
);
    localparam int TO_W = $clog2(MD_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MD_TIMEOUT);
    localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [TO_W-1:0]  cnt_q, cnt_d;
    logic             exc_q, exc_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    // Enable vector order: {pc, fd, dx, xm, mw}; flush vector order: {fd, dx, xm}.
    logic [4:0] en;
    logic [2:0] fl;
    logic       pc_sel;
    logic       start;
    logic       exc_out;
    logic       load_use;

    always_comb begin
        load_use = bus.ex_is_load && (bus.ex_rd != 5'd0) &&
                   ((bus.id_uses_rs && (bus.id_rs == bus.ex_rd)) ||
                    (bus.id_uses_rt && (bus.id_rt == bus.ex_rd)));
    end

    always_comb begin
        en      = 5'b11111;
        fl      = 3'b000;
        pc_sel  = 1'b0;
        start   = 1'b0;
        exc_out = 1'b0;
        if (reset) begin
            fl = 3'b111;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.ex_is_md) begin
                        // Freeze the front end and bubble X/M while mult/div runs.
                        en    = 5'b00011;
                        fl    = 3'b001;
                        start = 1'b1;
                    end else if (bus.branch_taken) begin
                        pc_sel = 1'b1;
                        fl     = 3'b110;
                    end else if (load_use) begin
                        en = 5'b00111;
                        fl = 3'b010;
                    end
                end
                ST_WAIT: begin
                    en = 5'b00011;
                    fl = 3'b001;
                end
                ST_DONE: begin
                    exc_out = exc_q;
                end
                default: begin
                    en = 5'b11111;
                end
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        exc_d   = exc_q;
        stall_d = stall_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.ex_is_md) begin
                    state_d = ST_WAIT;
                    cnt_d   = TO_ONE;
                end
            end
            ST_WAIT: begin
                // A ready on the timeout cycle wins: it is a real completion.
                if (bus.md_ready) begin
                    state_d = ST_DONE;
                    exc_d   = bus.md_exc;
                end else if (cnt_q == TO_LIMIT) begin
                    state_d = ST_DONE;
                    exc_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + TO_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (!en[4] && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            exc_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            exc_q   <= exc_d;
            stall_q <= stall_d;
        end
    end

    assign bus.pc_en         = en[4];
    assign bus.fd_en         = en[3];
    assign bus.dx_en         = en[2];
    assign bus.xm_en         = en[1];
    assign bus.mw_en         = en[0];
    assign bus.fd_flush      = fl[2];
    assign bus.dx_flush      = fl[1];
    assign bus.xm_flush      = fl[0];
    assign bus.pc_sel_target = pc_sel;
    assign bus.md_start      = start;
    assign bus.md_busy       = (state_q == ST_WAIT);
    assign bus.md_exc_out    = exc_out;
    assign bus.stall_cycles  = stall_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus randomized traffic, all
// checked against a cycle-level behavioural model of the control rules.
module tb_pipeline_ctrl;
    localparam int TO = 40;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    pipeline_ctrl_if #(.CNT_W(32)) bus ();

    pipeline_ctrl #(.MD_TIMEOUT(TO), .CNT_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Model state: whether a mult/div op is outstanding, when it started,
    // whether its one-cycle completion is pending, and the stall total.
    bit          m_wait;
    bit          m_done;
    bit          m_exc;
    int          m_start_cyc;
    int          cyc;
    logic [31:0] m_stall;
    logic [11:0] exp_vec;

    // Packed as {pc,fd,dx,xm,mw, fd_fl,dx_fl,xm_fl, pc_sel, start, busy, exc_out}
    function automatic logic [11:0] obs_vec();
        return {bus.pc_en, bus.fd_en, bus.dx_en, bus.xm_en, bus.mw_en,
                bus.fd_flush, bus.dx_flush, bus.xm_flush,
                bus.pc_sel_target, bus.md_start, bus.md_busy, bus.md_exc_out};
    endfunction

    function automatic logic [11:0] model_eval();
        bit hazard;
        hazard = bus.ex_is_load && bus.ex_rd != 0 &&
                 ((bus.id_uses_rs && bus.id_rs == bus.ex_rd) ||
                  (bus.id_uses_rt && bus.id_rt == bus.ex_rd));
        if (reset)             return {5'b11111, 3'b111, 1'b0, 1'b0, m_wait, 1'b0};
        if (m_done)            return {5'b11111, 3'b000, 1'b0, 1'b0, 1'b0, m_exc};
        if (m_wait)            return {5'b00011, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0};
        if (bus.ex_is_md)      return {5'b00011, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0};
        if (bus.branch_taken)  return {5'b11111, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0};
        if (hazard)            return {5'b00111, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0};
        return {5'b11111, 3'b000, 4'b0000};
    endfunction

    task automatic model_advance();
        if (reset) begin
            m_wait  = 0;
            m_done  = 0;
            m_exc   = 0;
            m_stall = '0;
        end else begin
            if (!exp_vec[11] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            if (m_done) begin
                m_done = 0;
            end else if (m_wait) begin
                if (bus.md_ready) begin
                    m_wait = 0; m_done = 1; m_exc = bus.md_exc;
                end else if (cyc - m_start_cyc == TO) begin
                    m_wait = 0; m_done = 1; m_exc = 1;
                end
            end else if (bus.ex_is_md) begin
                m_wait = 1;
                m_start_cyc = cyc;
            end
        end
        cyc++;
    endtask

    task automatic settle();
        #1;
        exp_vec = model_eval();
    endtask

    task automatic tick();
        @(posedge clock);
        model_advance();
        #1;
    endtask

    task automatic clear_inputs();
        bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rs = 0; bus.id_uses_rt = 0;
        bus.ex_is_load = 0; bus.ex_rd = 0; bus.ex_is_md = 0;
        bus.md_ready = 0; bus.md_exc = 0; bus.branch_taken = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        settle();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.ex_is_md = 1; bus.branch_taken = 1;
        reset = 1'b1;
        settle();
        tests++;
        if (obs_vec() !== 12'b11111_111_0_0_0_0) begin
            fails++; $display("FAIL reset_outputs got=%b want=%b", obs_vec(), 12'b111111110000);
        end
        tick();
        reset = 1'b0;
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            settle();
            tests++;
            if (obs_vec() !== 12'b11111_000_0000 || bus.stall_cycles !== 32'd0) begin
                fails++; $display("FAIL idle_%0d got=%b stall=%0d want=%b stall=0",
                                  i, obs_vec(), bus.stall_cycles, 12'b111110000000);
            end
            tick();
        end
        $display("[TB] reset + 3 idle cycles done");
    endtask

    task automatic test_load_use();
        do_reset();
        bus.ex_is_load = 1; bus.ex_rd = 5; bus.id_rs = 5; bus.id_uses_rs = 1;
        settle();
        tests++;
        if (obs_vec() !== exp_vec || bus.pc_en !== 1'b0 || bus.fd_en !== 1'b0 || bus.dx_flush !== 1'b1) begin
            fails++; $display("FAIL load_use_stall got=%b want=%b", obs_vec(), exp_vec);
        end
        tick();
        bus.ex_is_load = 0;
        settle();
        tests++;
        if (obs_vec() !== 12'b11111_000_0000 || bus.stall_cycles !== 32'd1) begin
            fails++; $display("FAIL load_use_release got=%b stall=%0d want=%b stall=1",
                              obs_vec(), bus.stall_cycles, 12'b111110000000);
        end
        tick();
        bus.ex_is_load = 1; bus.ex_rd = 7; bus.id_rt = 7; bus.id_uses_rt = 1; bus.id_uses_rs = 0;
        settle();
        tests++;
        if (bus.pc_en !== 1'b0 || bus.dx_flush !== 1'b1) begin
            fails++; $display("FAIL load_use_rt pc_en=%b dx_flush=%b want 0/1", bus.pc_en, bus.dx_flush);
        end
        tick();
        $display("[TB] load-use stall done");
    endtask

    task automatic test_load_rd0_and_branch();
        do_reset();
        bus.ex_is_load = 1; bus.ex_rd = 0; bus.id_rs = 0; bus.id_uses_rs = 1;
        settle();
        tests++;
        if (obs_vec() !== 12'b11111_000_0000) begin
            fails++; $display("FAIL load_rd0 got=%b want=%b", obs_vec(), 12'b111110000000);
        end
        tick();
        bus.ex_rd = 9; bus.id_rs = 9; bus.branch_taken = 1;
        settle();
        tests++;
        if (obs_vec() !== 12'b11111_110_1_000) begin
            fails++; $display("FAIL branch_over_load got=%b want=%b", obs_vec(), 12'b111111101000);
        end
        tick();
        clear_inputs();
        settle();
        tests++;
        if (bus.stall_cycles !== 32'd0) begin
            fails++; $display("FAIL branch_stall_count got=%0d want=0", bus.stall_cycles);
        end
        tick();
        $display("[TB] rd0 and branch priority done");
    endtask

    task automatic test_md_normal();
        do_reset();
        bus.ex_is_md = 1;
        settle();
        tests++;
        if (obs_vec() !== 12'b00011_001_0_1_0_0) begin
            fails++; $display("FAIL md_start_cycle got=%b want=%b", obs_vec(), 12'b000110010100);
        end
        tick();
        for (int k = 1; k <= 33; k++) begin
            bus.md_ready = (k == 33);
            bus.branch_taken = (k == 10);
            settle();
            tests++;
            if (obs_vec() !== exp_vec || bus.md_start !== 1'b0 || bus.md_busy !== 1'b1 || bus.xm_flush !== 1'b1) begin
                fails++; $display("FAIL md_wait_%0d got=%b want=%b", k, obs_vec(), exp_vec);
            end
            tick();
        end
        bus.md_ready = 0; bus.branch_taken = 1;
        settle();
        tests++;
        if (obs_vec() !== 12'b11111_000_0000 || bus.stall_cycles !== 32'd34) begin
            fails++; $display("FAIL md_done got=%b stall=%0d want=%b stall=34",
                              obs_vec(), bus.stall_cycles, 12'b111110000000);
        end
        tick();
        clear_inputs();
        settle();
        tests++;
        if (obs_vec() !== 12'b11111_000_0000) begin
            fails++; $display("FAIL md_after_done got=%b want=%b", obs_vec(), 12'b111110000000);
        end
        tick();
        $display("[TB] mult/div normal completion done");
    endtask

    task automatic test_md_timeout();
        int n;
        do_reset();
        bus.ex_is_md = 1;
        settle();
        tick();
        n = 0;
        for (int i = 0; i < 100; i++) begin
            settle();
            if (!bus.md_busy) break;
            n++;
            tick();
        end
        tests++;
        if (n !== TO) begin
            fails++; $display("FAIL md_timeout_len got=%0d want=%0d", n, TO);
        end
        tests++;
        if (obs_vec() !== 12'b11111_000_0001) begin
            fails++; $display("FAIL md_timeout_done got=%b want=%b", obs_vec(), 12'b111110000001);
        end
        tick();
        bus.ex_is_md = 0;
        settle();
        tests++;
        if (bus.md_exc_out !== 1'b0 || bus.md_busy !== 1'b0 || bus.stall_cycles !== 32'(TO + 1)) begin
            fails++; $display("FAIL md_timeout_after exc=%b busy=%b stall=%0d want 0/0/%0d",
                              bus.md_exc_out, bus.md_busy, bus.stall_cycles, TO + 1);
        end
        tick();
        $display("[TB] mult/div timeout done");
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        bus.ex_is_md = 1;
        settle();
        tick();
        for (int k = 1; k <= 4; k++) begin
            settle();
            tick();
        end
        reset = 1'b1;
        settle();
        tests++;
        if (bus.pc_en !== 1'b1 || bus.fd_flush !== 1'b1 || bus.xm_flush !== 1'b1 || bus.md_start !== 1'b0) begin
            fails++; $display("FAIL reset_mid_wait_cycle got=%b", obs_vec());
        end
        tick();
        reset = 1'b0;
        bus.ex_is_md = 0; bus.md_ready = 1; bus.md_exc = 1;
        settle();
        tests++;
        if (obs_vec() !== 12'b11111_000_0000 || bus.stall_cycles !== 32'd0) begin
            fails++; $display("FAIL reset_mid_wait_after got=%b stall=%0d want=%b stall=0",
                              obs_vec(), bus.stall_cycles, 12'b111110000000);
        end
        tick();
        bus.md_ready = 0; bus.md_exc = 0;
        settle();
        tests++;
        if (obs_vec() !== 12'b11111_000_0000) begin
            fails++; $display("FAIL stray_ready got=%b want=%b", obs_vec(), 12'b111110000000);
        end
        tick();
        $display("[TB] reset during wait done");
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            bus.id_rs = 5'($urandom_range(0, 3));
            bus.id_rt = 5'($urandom_range(0, 3));
            bus.id_uses_rs = 1'($urandom_range(0, 1));
            bus.id_uses_rt = 1'($urandom_range(0, 1));
            bus.ex_rd = 5'($urandom_range(0, 3));
            bus.ex_is_md = ($urandom_range(0, 19) == 0);
            bus.ex_is_load = !bus.ex_is_md && ($urandom_range(0, 2) == 0);
            bus.branch_taken = !bus.ex_is_md && ($urandom_range(0, 5) == 0);
            bus.md_ready = ($urandom_range(0, 29) == 0);
            bus.md_exc = 1'($urandom_range(0, 1));
            settle();
            tests++;
            if (obs_vec() !== exp_vec || bus.stall_cycles !== m_stall) begin
                fails++; bad++;
                if (bad <= 10)
                    $display("FAIL random_%0d got=%b stall=%0d want=%b stall=%0d",
                             i, obs_vec(), bus.stall_cycles, exp_vec, m_stall);
            end
            tick();
        end
        reset = 1'b0;
        $display("[TB] random traffic: 3000 cycles, stall total %0d", m_stall);
    endtask

    initial begin
        cyc = 0; m_wait = 0; m_done = 0; m_exc = 0; m_start_cyc = 0; m_stall = '0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_load_rd0_and_branch();
        test_md_normal();
        test_md_timeout();
        test_reset_mid_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
